// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM, datapath and ALU control.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        RST_WAIT = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEMADR   = 4'd3,
        MEMRD    = 4'd4,
        MEMWB    = 4'd5,
        MEMWR    = 4'd6,
        EXEC     = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        ADDIEX   = 4'd10,
        ADDIWB   = 4'd11,
        JUMP     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // True in the last cycle of an instruction that completes normally.
    function automatic logic retires(input state_t s, input logic mem_ready);
        case (s)
            MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: retires = 1'b1;
            MEMWR:                              retires = mem_ready;
            default:                            retires = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational state-to-output decoder for the multi-cycle MIPS control FSM.
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  logic [3:0] state_i,
    input  logic       mem_ready_i,
    input  logic       zero_i,
    output logic       pc_en_o,
    output logic       ir_en_o,
    output logic       mdr_en_o,
    output logic       ab_en_o,
    output logic       aluout_en_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       iord_o,
    output logic       reg_write_o,
    output logic       regdst_o,
    output logic       memtoreg_o,
    output logic       alusrca_o,
    output logic [1:0] alusrcb_o,
    output logic [1:0] aluop_o,
    output logic [1:0] pcsrc_o
);

    // Decode enables, strobes and mux selects; everything idles at 0 unless a state sets it.
    always_comb begin
        pc_en_o     = 1'b0;
        ir_en_o     = 1'b0;
        mdr_en_o    = 1'b0;
        ab_en_o     = 1'b0;
        aluout_en_o = 1'b0;
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        iord_o      = 1'b0;
        reg_write_o = 1'b0;
        regdst_o    = 1'b0;
        memtoreg_o  = 1'b0;
        alusrca_o   = 1'b0;
        alusrcb_o   = SRCB_B;
        aluop_o     = ALUOP_ADD;
        pcsrc_o     = PCSRC_ALU;
        case (state_i)
            FETCH: begin
                mem_read_o = 1'b1;
                alusrcb_o  = SRCB_FOUR;
                // PC+4 and IR load only on the completing cycle, so the PC steps once per fetch.
                pc_en_o    = mem_ready_i;
                ir_en_o    = mem_ready_i;
            end
            DECODE: begin
                ab_en_o     = 1'b1;
                aluout_en_o = 1'b1;
                alusrcb_o   = SRCB_IMMSH2;
            end
            MEMADR, ADDIEX: begin
                alusrca_o   = 1'b1;
                alusrcb_o   = SRCB_IMM;
                aluout_en_o = 1'b1;
            end
            MEMRD: begin
                mem_read_o = 1'b1;
                iord_o     = 1'b1;
                mdr_en_o   = mem_ready_i;
            end
            MEMWB: begin
                reg_write_o = 1'b1;
                memtoreg_o  = 1'b1;
            end
            MEMWR: begin
                mem_write_o = 1'b1;
                iord_o      = 1'b1;
            end
            EXEC: begin
                alusrca_o   = 1'b1;
                aluop_o     = ALUOP_FUNCT;
                aluout_en_o = 1'b1;
            end
            ALUWB: begin
                reg_write_o = 1'b1;
                regdst_o    = 1'b1;
            end
            BRANCH: begin
                alusrca_o = 1'b1;
                aluop_o   = ALUOP_SUB;
                pcsrc_o   = PCSRC_ALUOUT;
                pc_en_o   = zero_i;
            end
            ADDIWB: begin
                reg_write_o = 1'b1;
            end
            JUMP: begin
                pcsrc_o = PCSRC_JUMP;
                pc_en_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// Main control FSM for the multi-cycle MIPS datapath: state register, next-state
// logic and retired-instruction counter; output decoding lives in mips_ctrl_outdec.
module mips_mc_control
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ir_en,
    output logic             mdr_en,
    output logic             ab_en,
    output logic             aluout_en,
    output logic             mem_read,
    output logic             mem_write,
    output logic             iord,
    output logic             reg_write,
    output logic             regdst,
    output logic             memtoreg,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       aluop,
    output logic [1:0]       pcsrc,
    output logic             illegal,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    // State and counter registers; reset aborts any in-flight access immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RST_WAIT;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Next-state selection, illegal-opcode flag and retire counting.
    always_comb begin
        state_d   = state_q;
        illegal   = 1'b0;
        retired_d = retired_q;
        case (state_q)
            RST_WAIT: state_d = FETCH;
            FETCH:    if (mem_ready) state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default: begin
                        state_d = FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            MEMADR:   state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:    if (mem_ready) state_d = MEMWB;
            MEMWR:    if (mem_ready) state_d = FETCH;
            EXEC:     state_d = ALUWB;
            ADDIEX:   state_d = ADDIWB;
            MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: state_d = FETCH;
            default:  state_d = FETCH;
        endcase
        // Counter wraps naturally at 2^CNT_W.
        if (retires(state_q, mem_ready)) retired_d = retired_q + CNT_W'(1);
    end

    assign retired = retired_q;
    assign state   = state_q;

    mips_ctrl_outdec u_outdec (
        .state_i     (state_q),
        .mem_ready_i (mem_ready),
        .zero_i      (zero),
        .pc_en_o     (pc_en),
        .ir_en_o     (ir_en),
        .mdr_en_o    (mdr_en),
        .ab_en_o     (ab_en),
        .aluout_en_o (aluout_en),
        .mem_read_o  (mem_read),
        .mem_write_o (mem_write),
        .iord_o      (iord),
        .reg_write_o (reg_write),
        .regdst_o    (regdst),
        .memtoreg_o  (memtoreg),
        .alusrca_o   (alusrca),
        .alusrcb_o   (alusrcb),
        .aluop_o     (aluop),
        .pcsrc_o     (pcsrc)
    );

endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
Main control FSM for the multi-cycle MIPS datapath. It sequences the clock-enabled datapath registers (PC, IR, MDR, A/B, ALUOut) and the register file. It drives the mux selects, ALU op class and memory strobes, and waits on a memory ready handshake. It sits beside the datapath and is the only source of pc_en, ir_en and the other register clock enables.

Parameters:
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low
opcode  in  6  IR[31:26], valid from DECODE onward
zero  in  1  ALU zero flag, sampled in BRANCH
mem_ready  in  1  memory done; completes a FETCH/MEMRD/MEMWR access this cycle
pc_en  out  1  PC register clken
ir_en  out  1  IR register clken
mdr_en  out  1  MDR clken
ab_en  out  1  A/B register clken
aluout_en  out  1  ALUOut clken
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
iord  out  1  0 = PC address, 1 = ALUOut address
reg_write  out  1  register-file write enable
regdst  out  1  1 = rd, 0 = rt
memtoreg  out  1  1 = MDR, 0 = ALUOut
alusrca  out  1  0 = PC, 1 = A
alusrcb  out  2  00 = B, 01 = const 4, 10 = signext imm, 11 = signext imm<<2
aluop  out  2  00 = add, 01 = sub, 10 = funct-decoded
pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
illegal  out  1  one-cycle pulse on an unknown opcode
retired  out  CNT_W  count of completed instructions
state  out  4  current state, for debug

Behaviour:
- States (4-bit encoding): RST_WAIT=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, ADDIEX=10, ADDIWB=11, JUMP=12.
- Reset (rst low): state=RST_WAIT, retired=0. In RST_WAIT all outputs are 0, including aluop, alusrcb and pcsrc. Next state is FETCH unconditionally.
- All outputs except state and retired are combinational from state, gated by mem_ready and zero as listed below. Unlisted outputs are 0.
- FETCH: mem_read=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00. pc_en and ir_en equal mem_ready. Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1. The PC advances exactly once per fetch.
- DECODE: ab_en=1, aluout_en=1, alusrca=0, alusrcb=11, aluop=00. Next state by opcode:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 (R-type) -> EXEC
  - 000100 (beq) -> BRANCH
  - 001000 (addi) -> ADDIEX
  - 000010 (j) -> JUMP
  - any other -> FETCH, with illegal=1 for this cycle; retired does not increment
- MEMADR: alusrca=1, alusrcb=10, aluop=00, aluout_en=1. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: mem_read=1, iord=1, mdr_en=mem_ready. Stay until mem_ready=1, then MEMWB.
- MEMWB: reg_write=1, regdst=0, memtoreg=1. Next FETCH; retired++.
- MEMWR: mem_write=1, iord=1. Stay until mem_ready=1, then FETCH; retired++ on the exit cycle. mem_write stays high for the whole wait.
- EXEC: alusrca=1, alusrcb=00, aluop=10, aluout_en=1. Next ALUWB.
- ALUWB: reg_write=1, regdst=1, memtoreg=0. Next FETCH; retired++.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, pc_en=zero. Next FETCH; retired++ whether or not the branch is taken.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00, aluout_en=1. Next ADDIWB.
- ADDIWB: reg_write=1, regdst=0, memtoreg=0. Next FETCH; retired++.
- JUMP: pcsrc=10, pc_en=1. Next FETCH; retired++.
- retired wraps modulo 2^CNT_W with no saturation.
- Encodings 13-15 are unreachable. If entered, next state is FETCH and all outputs are 0.
- Reset asserted mid-instruction: state returns to RST_WAIT immediately, which aborts any pending memory access and drops its strobes that cycle.
- mem_ready outside FETCH, MEMRD and MEMWR is ignored.
- Cycle counts with mem_ready tied to 1:
  - lw = 5
  - R-type, addi and sw = 4
  - beq and j = 3

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state encoding constants
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J)
  - aluop, alusrcb and pcsrc encodings
- The datapath and the ALU control block reuse this package.
- One sub-module, mips_ctrl_outdec, holds the combinational state-to-output decoder. The main module keeps the state register, the next-state logic and the retired counter.

Test Plan:
- Reset release, mem_ready=1, opcode=000000 -> state sequence 0,1,2,7,8,1. pc_en high only in the first FETCH cycle. reg_write=1 and regdst=1 in ALUWB. retired=1.
- lw with mem_ready low for 3 cycles in FETCH and 2 cycles in MEMRD -> pc_en and ir_en pulse once, on the ready cycle. mdr_en pulses once. The instruction takes 10 cycles. retired increments once.
- beq with zero=1, then beq with zero=0 -> pc_en=1 with pcsrc=01 in the first BRANCH, pc_en=0 in the second. retired increases by 2.
- opcode=111111 in DECODE -> illegal pulses for 1 cycle. Next state is FETCH. retired is unchanged.
- sw with rst driven low during the MEMWR wait -> mem_write drops within the same cycle, state=0, retired=0. The next cycle after rst rises, state=FETCH.
- Preload retired to 2^CNT_W-1 (via a force) and run j -> retired wraps to 0. pcsrc=10 and pc_en=1 in JUMP.
